// File: rtl/weight_load_16_pkg.sv
// Shared weight-RAM address map: layer codes, per-layer base rows, row geometry and FSM states.
// The weight-store reader and this writer both use it, so they always agree on the map.
package weight_load_16_pkg;

    localparam int DATA_LEN       = 8;
    localparam int DEPTH          = 256;
    localparam int AW             = $clog2(DEPTH);
    localparam int ROWS_PER_LAYER = 32;
    localparam int RCW            = $clog2(ROWS_PER_LAYER);
    localparam int WORDS_PER_ROW  = 9;
    localparam int WCW            = $clog2(WORDS_PER_ROW);
    localparam int ROW_W          = WORDS_PER_ROW * DATA_LEN;

    localparam logic [3:0] LAYER0 = 4'd0;
    localparam logic [3:0] LAYER1 = 4'd1;
    localparam logic [3:0] LAYER2 = 4'd2;
    localparam logic [3:0] LAYER3 = 4'd3;
    localparam logic [3:0] AFFINE = 4'd4;

    localparam logic [AW-1:0] BASE_LAYER0 = 8'd0;
    localparam logic [AW-1:0] BASE_LAYER1 = 8'd32;
    localparam logic [AW-1:0] BASE_LAYER2 = 8'd64;
    localparam logic [AW-1:0] BASE_LAYER3 = 8'd96;
    localparam logic [AW-1:0] BASE_AFFINE = 8'd128;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_WRITE = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    function automatic logic layer_valid(input logic [3:0] cs);
        case (cs)
            LAYER0, LAYER1, LAYER2, LAYER3, AFFINE: layer_valid = 1'b1;
            default:                                layer_valid = 1'b0;
        endcase
    endfunction

    function automatic logic [AW-1:0] layer_base(input logic [3:0] cs);
        case (cs)
            LAYER1:  layer_base = BASE_LAYER1;
            LAYER2:  layer_base = BASE_LAYER2;
            LAYER3:  layer_base = BASE_LAYER3;
            AFFINE:  layer_base = BASE_AFFINE;
            default: layer_base = BASE_LAYER0;
        endcase
    endfunction

endpackage

// File: rtl/weight_load_16_row_packer_9.sv
// 9-lane row buffer: each pushed word lands in lane word_cnt; full_o flags the push of lane 8.
// row_nxt_o already contains the word being pushed this cycle, so the row can be registered on that edge.
module weight_load_16_row_packer_9
    import weight_load_16_pkg::*;
(
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   clear_i,
    input  logic                                   push_i,
    input  logic [DATA_LEN-1:0]                    din_i,
    output logic [WORDS_PER_ROW-1:0][DATA_LEN-1:0] row_nxt_o,
    output logic                                   full_o
);

    logic [WORDS_PER_ROW-1:0][DATA_LEN-1:0] buf_q;
    logic [WCW-1:0]                         cnt_q;
    logic [WCW-1:0]                         cnt_d;
    logic                                   last_lane;

    assign last_lane = (cnt_q == WCW'(WORDS_PER_ROW - 1));
    assign full_o    = push_i && last_lane;

    always_comb begin
        row_nxt_o = buf_q;
        if (push_i) begin
            row_nxt_o[cnt_q] = din_i;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (push_i) begin
            cnt_d = last_lane ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q <= '0;
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (push_i && !clear_i) begin
                buf_q <= row_nxt_o;
            end
        end
    end

endmodule

// File: rtl/weight_load_16.sv
// Weight RAM writer: packs 9 stream words per row, writes 32 rows at layer base + row; one bubble per row.
// Optional trailing checksum word under WLOAD_CHECKSUM_EN; in_valid stalls indefinitely, in_ready only in FILL/CHECK.
module weight_load_16
    import weight_load_16_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic [3:0]          cs_i,
    input  logic                in_valid_i,
    input  logic [DATA_LEN-1:0] din_i,
    output logic                in_ready_o,
    output logic                we_o,
    output logic [AW-1:0]       waddr_o,
    output logic [ROW_W-1:0]    wdata_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o
);

    state_t                                 state_q;
    logic [AW-1:0]                          base_q;
    logic [RCW-1:0]                         row_cnt_q;
    logic                                   in_ready_q;
    logic                                   we_q;
    logic [AW-1:0]                          waddr_q;
    logic [ROW_W-1:0]                       wdata_q;
    logic                                   busy_q;
    logic                                   done_q;

    logic                                   accept;
    logic                                   start_ok;
    logic                                   pk_push;
    logic                                   pk_full;
    logic [WORDS_PER_ROW-1:0][DATA_LEN-1:0] pk_row_nxt;
    logic                                   last_row;

    assign accept   = in_valid_i && in_ready_q;
    assign start_ok = (state_q == S_IDLE) && start_i && layer_valid(cs_i);
    assign pk_push  = accept && (state_q == S_FILL);
    assign last_row = (row_cnt_q == RCW'(ROWS_PER_LAYER - 1));

    weight_load_16_row_packer_9 u_packer (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (start_ok),
        .push_i    (pk_push),
        .din_i     (din_i),
        .row_nxt_o (pk_row_nxt),
        .full_o    (pk_full)
    );

`ifdef WLOAD_CHECKSUM_EN
    logic [DATA_LEN-1:0] sum_q;
    logic                err_q;
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            row_cnt_q  <= '0;
            in_ready_q <= 1'b0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef WLOAD_CHECKSUM_EN
            sum_q      <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            we_q   <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_ok) begin
                        base_q     <= layer_base(cs_i);
                        row_cnt_q  <= '0;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= S_FILL;
`ifdef WLOAD_CHECKSUM_EN
                        sum_q      <= '0;
                        err_q      <= 1'b0;
`endif
                    end
                end
                S_FILL: begin
                    if (accept) begin
`ifdef WLOAD_CHECKSUM_EN
                        sum_q <= sum_q + din_i;
`endif
                        // Ninth word: the row (with this word merged) goes out on the next cycle.
                        if (pk_full) begin
                            in_ready_q <= 1'b0;
                            we_q       <= 1'b1;
                            waddr_q    <= base_q + AW'(row_cnt_q);
                            wdata_q    <= pk_row_nxt;
                            state_q    <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    row_cnt_q <= row_cnt_q + 1'b1;
                    if (last_row) begin
`ifdef WLOAD_CHECKSUM_EN
                        in_ready_q <= 1'b1;
                        state_q    <= S_CHECK;
`else
                        done_q     <= 1'b1;
                        state_q    <= S_DONE;
`endif
                    end else begin
                        in_ready_q <= 1'b1;
                        state_q    <= S_FILL;
                    end
                end
`ifdef WLOAD_CHECKSUM_EN
                S_CHECK: begin
                    if (accept) begin
                        err_q      <= (din_i != sum_q);
                        in_ready_q <= 1'b0;
                        done_q     <= 1'b1;
                        state_q    <= S_DONE;
                    end
                end
`endif
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b0;
                    state_q    <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready_o = in_ready_q;
    assign we_o       = we_q;
    assign waddr_o    = waddr_q;
    assign wdata_o    = wdata_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;

endmodule

// File: tb/tb_weight_load_16.sv
// Directed bench for weight_load_16: table of layer transfers plus reset, idle-valid and checksum sequences.
module tb_weight_load_16;
    import weight_load_16_pkg::*;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                start_i = 1'b0;
    logic [3:0]          cs_i = 4'd0;
    logic                in_valid_i = 1'b0;
    logic [DATA_LEN-1:0] din_i = '0;
    logic                in_ready_o;
    logic                we_o;
    logic [AW-1:0]       waddr_o;
    logic [ROW_W-1:0]    wdata_o;
    logic                busy_o;
    logic                done_o;
    logic                err_o;

    weight_load_16 dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .cs_i       (cs_i),
        .in_valid_i (in_valid_i),
        .din_i      (din_i),
        .in_ready_o (in_ready_o),
        .we_o       (we_o),
        .waddr_o    (waddr_o),
        .wdata_o    (wdata_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o)
    );

    always #5 clk = ~clk;

`ifdef WLOAD_CHECKSUM_EN
    localparam int NWORDS   = 289;
    localparam int XFER_LAT = 322;
`else
    localparam int NWORDS   = 288;
    localparam int XFER_LAT = 321;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    logic done_err = 1'b0;
    logic [AW-1:0]    we_addr[$];
    logic [ROW_W-1:0] we_data[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (we_o) begin
            we_addr.push_back(waddr_o);
            we_data.push_back(wdata_o);
        end
        if (done_o) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
            done_err = err_o;
        end
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [DATA_LEN-1:0] data_word(input int mode, input int i);
        int v;
        v = (mode == 0) ? (i % 256) : 1;
        return DATA_LEN'(v);
    endfunction

    function automatic logic [ROW_W-1:0] exp_row(input int mode, input int r);
        logic [ROW_W-1:0] row;
        row = '0;
        for (int j = 0; j < WORDS_PER_ROW; j++)
            row[j*DATA_LEN +: DATA_LEN] = data_word(mode, r*WORDS_PER_ROW + j);
        return row;
    endfunction

    function automatic logic [DATA_LEN-1:0] data_sum(input int mode);
        logic [DATA_LEN-1:0] s;
        s = '0;
        for (int i = 0; i < 288; i++) s = s + data_word(mode, i);
        return s;
    endfunction

    // Drives one transfer; feeds stop_after words, then (if complete) waits for done.
    // lat = clock edges from the start edge to the edge that raises done.
    task automatic run_xfer(input logic [3:0] cs, input bit gaps, input int mode, input int stop_after,
                            input bit restart, input logic [DATA_LEN-1:0] csum, output int lat);
        int widx;
        int guard;
        int d0;
        int c0;
        bit tog;
        bit v;
        we_addr.delete();
        we_data.delete();
        lat = -1;
        d0 = done_cnt;
        @(negedge clk);
        start_i = 1'b1;
        cs_i = cs;
        c0 = cyc;
        @(negedge clk);
        start_i = 1'b0;
        chk("busy_after_start", busy_o, 1'b1);
        widx = 0;
        guard = 0;
        tog = 1'b0;
        while (widx < stop_after && guard < 4000) begin
            tog = ~tog;
            v = gaps ? tog : 1'b1;
            in_valid_i = v;
            din_i = (widx < 288) ? data_word(mode, widx) : csum;
            if (restart && widx == 50) begin
                start_i = 1'b1;
                cs_i = LAYER3;
            end else begin
                start_i = 1'b0;
            end
            if (v && in_ready_o) widx++;
            @(negedge clk);
            guard++;
        end
        in_valid_i = 1'b0;
        start_i = 1'b0;
        chk("words_fed", widx, stop_after);
        if (stop_after >= NWORDS) begin
            guard = 0;
            while (done_cnt == d0 && guard < 2000) begin
                @(negedge clk);
                guard++;
            end
            chk("done_seen", done_cnt - d0, 1);
            lat = done_cyc - c0;
            @(negedge clk);
            chk("busy_after_done", busy_o, 1'b0);
            chk("done_one_cycle", done_o, 1'b0);
        end
    endtask

    typedef struct {
        logic [3:0]    cs;
        bit            gaps;
        bit            restart;
        bit            valid;
        logic [AW-1:0] base;
    } vec_t;

    vec_t vecs[6];
    int lat;

    initial begin
        vecs[0] = '{cs: LAYER1, gaps: 1'b0, restart: 1'b0, valid: 1'b1, base: 8'd32};
        vecs[1] = '{cs: AFFINE, gaps: 1'b1, restart: 1'b0, valid: 1'b1, base: 8'd128};
        vecs[2] = '{cs: 4'hF,   gaps: 1'b0, restart: 1'b0, valid: 1'b0, base: 8'd0};
        vecs[3] = '{cs: LAYER2, gaps: 1'b0, restart: 1'b1, valid: 1'b1, base: 8'd64};
        vecs[4] = '{cs: LAYER3, gaps: 1'b1, restart: 1'b0, valid: 1'b1, base: 8'd96};
        vecs[5] = '{cs: 4'd7,   gaps: 1'b0, restart: 1'b0, valid: 1'b0, base: 8'd0};

        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready_o, 1'b0);
        chk("rst_we", we_o, 1'b0);
        chk("rst_waddr", waddr_o, 8'd0);
        chk("rst_wdata", wdata_o, 72'd0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_done", done_o, 1'b0);
        chk("rst_err", err_o, 1'b0);
        rst = 1'b0;

        // in_valid in IDLE must not be consumed; the next transfer's row 0 lane 0 proves it.
        in_valid_i = 1'b1;
        din_i = 8'hAA;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("idle_in_ready", in_ready_o, 1'b0);
        end

        for (int t = 0; t < 6; t++) begin
            if (vecs[t].valid) begin
                run_xfer(vecs[t].cs, vecs[t].gaps, 0, NWORDS, vecs[t].restart, data_sum(0), lat);
                chk("we_count", we_addr.size(), ROWS_PER_LAYER);
                for (int r = 0; r < ROWS_PER_LAYER && r < we_addr.size(); r++) begin
                    chk($sformatf("waddr_v%0d_r%0d", t, r), we_addr[r], vecs[t].base + AW'(r));
                    chk($sformatf("wdata_v%0d_r%0d", t, r), we_data[r], exp_row(0, r));
                end
                chk("err_at_done", done_err, 1'b0);
                if (!vecs[t].gaps) chk("xfer_latency", lat, XFER_LAT);
            end else begin
                we_addr.delete();
                @(negedge clk);
                start_i = 1'b1;
                cs_i = vecs[t].cs;
                @(negedge clk);
                start_i = 1'b0;
                repeat (3) @(negedge clk);
                chk("bad_cs_busy", busy_o, 1'b0);
                chk("bad_cs_in_ready", in_ready_o, 1'b0);
                chk("bad_cs_no_we", we_addr.size(), 0);
            end
        end

        // Reset after word 13 of LAYER0: row 0 written, partial row 1 discarded.
        run_xfer(LAYER0, 1'b0, 0, 14, 1'b0, 8'd0, lat);
        rst = 1'b1;
        #1;
        chk("mid_rst_in_ready", in_ready_o, 1'b0);
        chk("mid_rst_we", we_o, 1'b0);
        chk("mid_rst_waddr", waddr_o, 8'd0);
        chk("mid_rst_wdata", wdata_o, 72'd0);
        chk("mid_rst_busy", busy_o, 1'b0);
        chk("mid_rst_done", done_o, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_rst_we_count", we_addr.size(), 1);
        if (we_addr.size() > 0) chk("mid_rst_waddr0", we_addr[0], 8'd0);
        chk("mid_rst_idle_busy", busy_o, 1'b0);

        run_xfer(LAYER0, 1'b0, 0, NWORDS, 1'b0, data_sum(0), lat);
        chk("l0_we_count", we_addr.size(), ROWS_PER_LAYER);
        for (int r = 0; r < ROWS_PER_LAYER && r < we_addr.size(); r++) begin
            chk($sformatf("l0_waddr_r%0d", r), we_addr[r], AW'(r));
            chk($sformatf("l0_wdata_r%0d", r), we_data[r], exp_row(0, r));
        end

`ifdef WLOAD_CHECKSUM_EN
        // All-ones stream: 288 mod 256 = 32.
        run_xfer(LAYER2, 1'b0, 1, NWORDS, 1'b0, 8'd32, lat);
        chk("csum_ok_err", done_err, 1'b0);
        chk("csum_ok_rows", we_data.size() > 0 ? we_data[0] : '0, {9{8'd1}});
        run_xfer(LAYER2, 1'b1, 1, NWORDS, 1'b0, 8'd33, lat);
        chk("csum_bad_err", done_err, 1'b1);
        chk("csum_bad_sticky", err_o, 1'b1);
        run_xfer(LAYER1, 1'b0, 1, 5, 1'b0, 8'd0, lat);
        chk("csum_cleared_on_start", err_o, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got %0d want 0", cyc);
        $fatal(1, "timeout");
    end

endmodule
